// File: rtl/obi_pkg.sv
// Shared OBI widths and the request payload carried from a master to the port.
package obi_pkg;

   localparam int unsigned OBI_ADDR_W = 32;
   localparam int unsigned OBI_DATA_W = 32;
   localparam int unsigned OBI_BE_W   = 4;

   typedef struct packed {
      logic [OBI_ADDR_W-1:0] addr;
      logic                  we;
      logic [OBI_BE_W-1:0]   be;
      logic [OBI_DATA_W-1:0] wdata;
   } obi_req_t;

endpackage

// File: rtl/obi_rr_arbiter_2.sv
// Two-way arbiter with round-robin or fixed priority and an address-phase lock
// that holds the selection while the downstream slave stalls.
module obi_rr_arbiter_2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       hs,
   input  logic       stall,
   output logic       sel
);

   logic last_gnt;
   logic lock_vld;
   logic lock_sel;

   // A stalled request keeps its master; otherwise arbitrate among requesters.
   always_comb begin
      sel = 1'b0;
      if (lock_vld) begin
         sel = lock_sel;
      end else if (req == 2'b10) begin
         sel = 1'b1;
      end else if (req == 2'b11) begin
         sel = RR_EN ? ~last_gnt : 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_gnt <= 1'b1;
         lock_vld <= 1'b0;
         lock_sel <= 1'b0;
      end else if (en) begin
         if (hs) begin
            last_gnt <= sel;
            lock_vld <= 1'b0;
         end else if (stall) begin
            lock_vld <= 1'b1;
            lock_sel <= sel;
         end
      end
   end

endmodule

// File: rtl/obi_mux_2_to_1.sv
// Merges two OBI masters onto one controller port; one outstanding read at a
// time, posted writes, responses routed back to the master that issued the read.
module obi_mux_2_to_1
   import obi_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ctrl0_req_i,
   output logic                  ctrl0_gnt_o,
   input  logic [OBI_ADDR_W-1:0] ctrl0_addr_i,
   input  logic                  ctrl0_we_i,
   input  logic [OBI_BE_W-1:0]   ctrl0_be_i,
   input  logic [OBI_DATA_W-1:0] ctrl0_wdata_i,
   output logic                  ctrl0_rvalid_o,
   output logic [OBI_DATA_W-1:0] ctrl0_rdata_o,
   input  logic                  ctrl1_req_i,
   output logic                  ctrl1_gnt_o,
   input  logic [OBI_ADDR_W-1:0] ctrl1_addr_i,
   input  logic                  ctrl1_we_i,
   input  logic [OBI_BE_W-1:0]   ctrl1_be_i,
   input  logic [OBI_DATA_W-1:0] ctrl1_wdata_i,
   output logic                  ctrl1_rvalid_o,
   output logic [OBI_DATA_W-1:0] ctrl1_rdata_o,
   output logic                  port_req_o,
   input  logic                  port_gnt_i,
   output logic [OBI_ADDR_W-1:0] port_addr_o,
   output logic                  port_we_o,
   output logic [OBI_BE_W-1:0]   port_be_o,
   output logic [OBI_DATA_W-1:0] port_wdata_o,
   input  logic                  port_rvalid_i,
   input  logic [OBI_DATA_W-1:0] port_rdata_i
);

   logic     rd_pend;
   logic     rsp_owner;
   logic     sel;
   logic     arb_en;
   logic     hs;
   logic     stall;
   logic     rsp;
   obi_req_t c0;
   obi_req_t c1;
   obi_req_t ps;

   assign c0 = '{addr: ctrl0_addr_i, we: ctrl0_we_i, be: ctrl0_be_i, wdata: ctrl0_wdata_i};
   assign c1 = '{addr: ctrl1_addr_i, we: ctrl1_we_i, be: ctrl1_be_i, wdata: ctrl1_wdata_i};

   // Returning response frees the single read slot in the same cycle.
   assign arb_en = ~rd_pend | port_rvalid_i;

   obi_rr_arbiter_2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    ({ctrl1_req_i, ctrl0_req_i}),
      .en     (arb_en),
      .hs     (hs),
      .stall  (stall),
      .sel    (sel)
   );

   assign ps           = sel ? c1 : c0;
   assign port_addr_o  = ps.addr;
   assign port_we_o    = ps.we;
   assign port_be_o    = ps.be;
   assign port_wdata_o = ps.wdata;

   assign port_req_o  = arb_en & (sel ? ctrl1_req_i : ctrl0_req_i);
   assign hs          = port_req_o & port_gnt_i;
   assign stall       = port_req_o & ~port_gnt_i;
   assign ctrl0_gnt_o = hs & ~sel;
   assign ctrl1_gnt_o = hs & sel;

   // Responses seen with no read outstanding are write acks or strays; drop them.
   assign rsp            = rd_pend & port_rvalid_i;
   assign ctrl0_rvalid_o = rsp & ~rsp_owner;
   assign ctrl1_rvalid_o = rsp & rsp_owner;
   assign ctrl0_rdata_o  = port_rdata_i;
   assign ctrl1_rdata_o  = port_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_pend   <= 1'b0;
         rsp_owner <= 1'b0;
      end else if (hs && !port_we_o) begin
         rd_pend   <= 1'b1;
         rsp_owner <= sel;
      end else if (port_rvalid_i) begin
         rd_pend   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_obi_mux_2_to_1.sv
// Directed bench for obi_mux_2_to_1: round-robin and fixed-priority instances
// share stimulus; read owners are queued at handshake and checked on response.
module tb_obi_mux_2_to_1;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ctrl0_req_i, ctrl0_we_i, ctrl1_req_i, ctrl1_we_i;
   logic [31:0] ctrl0_addr_i, ctrl0_wdata_i, ctrl1_addr_i, ctrl1_wdata_i;
   logic [3:0]  ctrl0_be_i, ctrl1_be_i;
   logic        port_gnt_i, port_rvalid_i;
   logic [31:0] port_rdata_i;

   logic        ctrl0_gnt_o, ctrl0_rvalid_o, ctrl1_gnt_o, ctrl1_rvalid_o;
   logic [31:0] ctrl0_rdata_o, ctrl1_rdata_o;
   logic        port_req_o, port_we_o;
   logic [31:0] port_addr_o, port_wdata_o;
   logic [3:0]  port_be_o;

   logic        fp_ctrl0_gnt, fp_ctrl0_rvalid, fp_ctrl1_gnt, fp_ctrl1_rvalid;
   logic [31:0] fp_ctrl0_rdata, fp_ctrl1_rdata;
   logic        fp_port_req, fp_port_we;
   logic [31:0] fp_port_addr, fp_port_wdata;
   logic [3:0]  fp_port_be;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_q[$];

   always #5 clk_i = ~clk_i;

   obi_mux_2_to_1 #(.RR_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ctrl0_req_i(ctrl0_req_i), .ctrl0_gnt_o(ctrl0_gnt_o), .ctrl0_addr_i(ctrl0_addr_i),
      .ctrl0_we_i(ctrl0_we_i), .ctrl0_be_i(ctrl0_be_i), .ctrl0_wdata_i(ctrl0_wdata_i),
      .ctrl0_rvalid_o(ctrl0_rvalid_o), .ctrl0_rdata_o(ctrl0_rdata_o),
      .ctrl1_req_i(ctrl1_req_i), .ctrl1_gnt_o(ctrl1_gnt_o), .ctrl1_addr_i(ctrl1_addr_i),
      .ctrl1_we_i(ctrl1_we_i), .ctrl1_be_i(ctrl1_be_i), .ctrl1_wdata_i(ctrl1_wdata_i),
      .ctrl1_rvalid_o(ctrl1_rvalid_o), .ctrl1_rdata_o(ctrl1_rdata_o),
      .port_req_o(port_req_o), .port_gnt_i(port_gnt_i), .port_addr_o(port_addr_o),
      .port_we_o(port_we_o), .port_be_o(port_be_o), .port_wdata_o(port_wdata_o),
      .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i)
   );

   obi_mux_2_to_1 #(.RR_EN(1'b0)) dut_fp (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ctrl0_req_i(ctrl0_req_i), .ctrl0_gnt_o(fp_ctrl0_gnt), .ctrl0_addr_i(ctrl0_addr_i),
      .ctrl0_we_i(ctrl0_we_i), .ctrl0_be_i(ctrl0_be_i), .ctrl0_wdata_i(ctrl0_wdata_i),
      .ctrl0_rvalid_o(fp_ctrl0_rvalid), .ctrl0_rdata_o(fp_ctrl0_rdata),
      .ctrl1_req_i(ctrl1_req_i), .ctrl1_gnt_o(fp_ctrl1_gnt), .ctrl1_addr_i(ctrl1_addr_i),
      .ctrl1_we_i(ctrl1_we_i), .ctrl1_be_i(ctrl1_be_i), .ctrl1_wdata_i(ctrl1_wdata_i),
      .ctrl1_rvalid_o(fp_ctrl1_rvalid), .ctrl1_rdata_o(fp_ctrl1_rdata),
      .port_req_o(fp_port_req), .port_gnt_i(port_gnt_i), .port_addr_o(fp_port_addr),
      .port_we_o(fp_port_we), .port_be_o(fp_port_be), .port_wdata_o(fp_port_wdata),
      .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pops the expected owner when a response is driven for an outstanding read.
   task automatic check_rsp(input logic rv, input logic [31:0] data);
      logic o;
      if (rv && exp_q.size() != 0) begin
         o = exp_q.pop_front();
         chk("rvalid_owner", 32'(o ? ctrl1_rvalid_o : ctrl0_rvalid_o), 32'd1);
         chk("rvalid_other", 32'(o ? ctrl0_rvalid_o : ctrl1_rvalid_o), 32'd0);
         chk("rdata", o ? ctrl1_rdata_o : ctrl0_rdata_o, data);
      end else begin
         chk("rvalid0_idle", 32'(ctrl0_rvalid_o), 32'd0);
         chk("rvalid1_idle", 32'(ctrl1_rvalid_o), 32'd0);
      end
   endtask

   task automatic idle_inputs();
      ctrl0_req_i = 1'b0; ctrl0_we_i = 1'b0; ctrl0_addr_i = '0; ctrl0_be_i = '0; ctrl0_wdata_i = '0;
      ctrl1_req_i = 1'b0; ctrl1_we_i = 1'b0; ctrl1_addr_i = '0; ctrl1_be_i = '0; ctrl1_wdata_i = '0;
      port_gnt_i = 1'b0; port_rvalid_i = 1'b0; port_rdata_i = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_port_req"}, 32'(port_req_o), 32'd0);
      chk({tag, "_gnt"}, 32'({ctrl1_gnt_o, ctrl0_gnt_o}), 32'd0);
      chk({tag, "_rvalid"}, 32'({ctrl1_rvalid_o, ctrl0_rvalid_o}), 32'd0);
      chk({tag, "_addr"}, port_addr_o, 32'd0);
      chk({tag, "_we_be"}, 32'({port_we_o, port_be_o}), 32'd0);
      chk({tag, "_wdata"}, port_wdata_o, 32'd0);
      chk({tag, "_rdata"}, ctrl0_rdata_o | ctrl1_rdata_o, 32'd0);
   endtask

   initial begin
      logic       m_last;
      logic       rv;
      logic       en;
      logic       s;
      logic       pend;
      logic [9:0] pat;
      logic [31:0] d;

      pat = 10'b11_0110_1011;
      idle_inputs();
      rst_ni = 1'b0;
      #3;
      chk_all_zero("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single ctrl0 read, response two cycles later.
      @(negedge clk_i);
      ctrl0_req_i = 1'b1; ctrl0_addr_i = 32'h0000_1000; port_gnt_i = 1'b1;
      #1;
      chk("rd0_port_req", 32'(port_req_o), 32'd1);
      chk("rd0_gnt0", 32'(ctrl0_gnt_o), 32'd1);
      chk("rd0_addr", port_addr_o, 32'h0000_1000);
      if (ctrl0_gnt_o) exp_q.push_back(1'b0);
      @(negedge clk_i);
      ctrl0_req_i = 1'b0; port_gnt_i = 1'b0;
      @(negedge clk_i);
      port_rvalid_i = 1'b1; port_rdata_i = 32'h1234_5678;
      #1;
      check_rsp(1'b1, 32'h1234_5678);
      m_last = 1'b0;

      // Both masters read continuously; slave grants at once, responds with gaps.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         pend = (exp_q.size() != 0);
         rv = pend && pat[i];
         d = $urandom;
         ctrl0_req_i = 1'b1; ctrl0_we_i = 1'b0; ctrl0_addr_i = 32'h100 + 32'(i);
         ctrl1_req_i = 1'b1; ctrl1_we_i = 1'b0; ctrl1_addr_i = 32'h200 + 32'(i);
         port_gnt_i = 1'b1; port_rvalid_i = rv; port_rdata_i = d;
         #1;
         check_rsp(rv, d);
         chk("fp_rvalid0", 32'(fp_ctrl0_rvalid), 32'(rv));
         chk("fp_rvalid1", 32'(fp_ctrl1_rvalid), 32'd0);
         en = !pend || rv;
         chk("rr_port_req", 32'(port_req_o), 32'(en));
         chk("fp_gnt", 32'({fp_ctrl1_gnt, fp_ctrl0_gnt}), 32'({1'b0, en}));
         if (en) begin
            s = ~m_last;
            chk("rr_gnt", 32'({ctrl1_gnt_o, ctrl0_gnt_o}), s ? 32'd2 : 32'd1);
            chk("rr_addr", port_addr_o, s ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
            exp_q.push_back(s);
            m_last = s;
         end else begin
            chk("rr_gnt_blocked", 32'({ctrl1_gnt_o, ctrl0_gnt_o}), 32'd0);
         end
      end
      @(negedge clk_i);
      idle_inputs();
      rv = (exp_q.size() != 0);
      port_rvalid_i = rv; port_rdata_i = 32'hA5A5_0001;
      #1;
      check_rsp(rv, 32'hA5A5_0001);

      // ctrl1 write makes ctrl1 the last winner, so a tie would now favour ctrl0.
      @(negedge clk_i);
      idle_inputs();
      ctrl1_req_i = 1'b1; ctrl1_we_i = 1'b1; ctrl1_addr_i = 32'h40; port_gnt_i = 1'b1;
      #1;
      chk("wr1_gnt", 32'(ctrl1_gnt_o), 32'd1);

      // Stalled ctrl1 request must keep the address phase through ctrl0 arrival.
      @(negedge clk_i);
      ctrl1_addr_i = 32'h8000_0004; port_gnt_i = 1'b0;
      #1;
      chk("lock_c1_addr", port_addr_o, 32'h8000_0004);
      chk("lock_c1_gnt", 32'(ctrl1_gnt_o), 32'd0);
      @(negedge clk_i);
      ctrl0_req_i = 1'b1; ctrl0_addr_i = 32'h0000_1111;
      #1;
      chk("lock_c2_addr", port_addr_o, 32'h8000_0004);
      chk("lock_c2_gnt0", 32'(ctrl0_gnt_o), 32'd0);
      @(negedge clk_i);
      #1;
      chk("lock_c3_addr", port_addr_o, 32'h8000_0004);
      @(negedge clk_i);
      port_gnt_i = 1'b1;
      #1;
      chk("lock_c4_gnt", 32'({ctrl1_gnt_o, ctrl0_gnt_o}), 32'd2);
      chk("lock_c4_addr", port_addr_o, 32'h8000_0004);

      // ctrl0 read, then its response overlaps a new ctrl1 read.
      @(negedge clk_i);
      ctrl1_req_i = 1'b0; ctrl1_we_i = 1'b0;
      #1;
      chk("ovl_gnt0", 32'(ctrl0_gnt_o), 32'd1);
      if (ctrl0_gnt_o) exp_q.push_back(1'b0);
      @(negedge clk_i);
      ctrl0_req_i = 1'b0;
      ctrl1_req_i = 1'b1; ctrl1_addr_i = 32'h8000_0008;
      port_rvalid_i = 1'b1; port_rdata_i = 32'hCAFE_F00D;
      #1;
      check_rsp(1'b1, 32'hCAFE_F00D);
      chk("ovl_gnt1", 32'(ctrl1_gnt_o), 32'd1);
      if (ctrl1_gnt_o) exp_q.push_back(1'b1);
      @(negedge clk_i);
      ctrl1_req_i = 1'b0; port_gnt_i = 1'b0;
      port_rdata_i = 32'h0BAD_C0DE;
      #1;
      check_rsp(1'b1, 32'h0BAD_C0DE);
      @(negedge clk_i);
      port_rdata_i = 32'h0000_0BAD;
      #1;
      check_rsp(1'b1, 32'h0000_0BAD);

      // Posted write, then a stray response that must not reach either master.
      @(negedge clk_i);
      idle_inputs();
      ctrl0_req_i = 1'b1; ctrl0_we_i = 1'b1; ctrl0_be_i = 4'hF;
      ctrl0_wdata_i = 32'hDEAD_BEEF; ctrl0_addr_i = 32'h2000; port_gnt_i = 1'b1;
      #1;
      chk("wr0_gnt", 32'(ctrl0_gnt_o), 32'd1);
      chk("wr0_we_be", 32'({port_we_o, port_be_o}), 32'h1F);
      chk("wr0_wdata", port_wdata_o, 32'hDEAD_BEEF);
      @(negedge clk_i);
      idle_inputs();
      port_rvalid_i = 1'b1; port_rdata_i = 32'h5555_AAAA;
      #1;
      check_rsp(1'b1, 32'h5555_AAAA);

      // Read goes outstanding, then reset lands between clock edges.
      @(negedge clk_i);
      idle_inputs();
      ctrl0_req_i = 1'b1; ctrl0_addr_i = 32'h3000; port_gnt_i = 1'b1;
      #1;
      chk("rst_rd_gnt", 32'(ctrl0_gnt_o), 32'd1);
      @(negedge clk_i);
      idle_inputs();
      #2;
      rst_ni = 1'b0;
      #1;
      chk_all_zero("async_rst");
      port_rvalid_i = 1'b1;
      #1;
      chk("rst_rvalid", 32'({ctrl1_rvalid_o, ctrl0_rvalid_o}), 32'd0);
      exp_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      port_rvalid_i = 1'b1; port_rdata_i = 32'h7777_7777;
      #1;
      check_rsp(1'b1, 32'h7777_7777);
      @(negedge clk_i);
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
